hilo_div_ctrl: RTL and testbench

//  Sequencer between the EX stage and the divider. Accepts DIV/DIVU/MTHI/MTLO
//  ops, pulses the divider start, waits a fixed latency, then writes divider
//  q->LO and r->HI. Serves MFHI/MFLO reads and stalls the pipeline while busy.

---
 rtl/hilo_div_ctrl_pkg.sv | 25 ++
 rtl/hilo_div_ctrl.sv | 127 ++++++++++++
 tb/tb_hilo_div_ctrl.sv | 314 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/hilo_div_ctrl_pkg.sv
// Shared encodings for the HI/LO divide sequencer: op codes and FSM states.
package hilo_div_ctrl_pkg;

    typedef enum logic [2:0] {
        OP_NOP  = 3'd0,
        OP_DIV  = 3'd1,
        OP_DIVU = 3'd2,
        OP_MTHI = 3'd3,
        OP_MTLO = 3'd4,
        OP_MFHI = 3'd5,
        OP_MFLO = 3'd6,
        OP_RSVD = 3'd7
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2
    } state_e;

    function automatic logic is_div_op(input op_e op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

endpackage

// File: rtl/hilo_div_ctrl.sv
// Sequencer between EX and an external divider: issues the start pulse, waits a
// fixed latency, captures q->LO / r->HI, and serves MTHI/MTLO/MFHI/MFLO.
//
// state   | meaning
// S_IDLE  | ready; accepts any op, MT writes and MF reads served here
// S_ISSUE | div_start pulsed, latency counter loaded
// S_WAIT  | counting down; capture q/r into LO/HI when counter reaches 0
module hilo_div_ctrl
    import hilo_div_ctrl_pkg::*;
#(
    parameter int DIV_LATENCY = 1,
    parameter int WIDTH       = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             op_valid,
    input  logic [2:0]       op_code,
    input  logic [WIDTH-1:0] rs_data,
    input  logic [WIDTH-1:0] rt_data,
    output logic [WIDTH-1:0] rdata,
    output logic             stall,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic             div_start,
    output logic             div_signed,
    output logic [WIDTH-1:0] div_dividend,
    output logic [WIDTH-1:0] div_divisor,
    input  logic [WIDTH-1:0] div_q,
    input  logic [WIDTH-1:0] div_r
);

    localparam int CNT_W = $clog2(DIV_LATENCY + 1);

    state_e           state;
    state_e           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    op_e              op;
    logic             accept;
    logic             div_req;
    logic             rt_zero;
    logic             div_go;
    logic             cnt_zero;

    assign op       = op_e'(op_code);
    assign accept   = op_valid && (state == S_IDLE);
    assign div_req  = accept && is_div_op(op);
    assign rt_zero  = (rt_data == '0);
    assign div_go   = div_req && !rt_zero;
    assign cnt_zero = (cnt == '0);

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (div_go) state_nxt = S_ISSUE;
            S_ISSUE: state_nxt = S_WAIT;
            S_WAIT:  if (cnt_zero) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Pulses are masked by reset so an abort in ISSUE/WAIT never leaks a start or done.
    always_comb begin
        busy      = (state != S_IDLE);
        div_start = (state == S_ISSUE) && !reset;
        done      = (state == S_WAIT) && cnt_zero && !reset;
        stall     = op_valid && busy;
        rdata     = '0;
        if (accept && (op == OP_MFHI)) rdata = hi;
        if (accept && (op == OP_MFLO)) rdata = lo;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt <= '0;
        end else if (state == S_ISSUE) begin
            cnt <= CNT_W'(DIV_LATENCY - 1);
        end else if ((state == S_WAIT) && !cnt_zero) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    // Operands stay frozen from accept until the next accepted divide.
    always_ff @(posedge clock) begin
        if (reset) begin
            div_dividend <= '0;
            div_divisor  <= '0;
            div_signed   <= 1'b0;
        end else if (div_go) begin
            div_dividend <= rs_data;
            div_divisor  <= rt_data;
            div_signed   <= (op == OP_DIV);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            div_zero <= 1'b0;
        end else begin
            div_zero <= div_req && rt_zero;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            hi <= '0;
            lo <= '0;
        end else if (done) begin
            lo <= div_q;
            hi <= div_r;
        end else if (accept) begin
            if (op == OP_MTHI) hi <= rs_data;
            if (op == OP_MTLO) lo <= rs_data;
        end
    end

endmodule

// File: tb/tb_hilo_div_ctrl.sv
// Self-checking bench for hilo_div_ctrl: unit 0 at DIV_LATENCY=1, unit 1 at DIV_LATENCY=4,
// each paired with a behavioural fixed-latency divider.
module tb_hilo_div_ctrl;

    localparam int LAT0 = 1;
    localparam int LAT1 = 4;

    logic        clock;
    logic        reset        [2];
    logic        op_valid     [2];
    logic [2:0]  op_code      [2];
    logic [31:0] rs_data      [2];
    logic [31:0] rt_data      [2];
    logic [31:0] rdata        [2];
    logic        stall        [2];
    logic        busy         [2];
    logic        done         [2];
    logic        div_zero     [2];
    logic        div_start    [2];
    logic        div_signed   [2];
    logic [31:0] div_dividend [2];
    logic [31:0] div_divisor  [2];
    logic [31:0] div_q        [2];
    logic [31:0] div_r        [2];

    logic [63:0] m_res  [2];
    int          m_rem  [2];
    logic        m_have [2];

    logic [63:0] sb[$];
    int checks   = 0;
    int failures = 0;

    hilo_div_ctrl #(.DIV_LATENCY(LAT0), .WIDTH(32)) dut0 (
        .clock(clock), .reset(reset[0]), .op_valid(op_valid[0]), .op_code(op_code[0]),
        .rs_data(rs_data[0]), .rt_data(rt_data[0]), .rdata(rdata[0]), .stall(stall[0]),
        .busy(busy[0]), .done(done[0]), .div_zero(div_zero[0]), .div_start(div_start[0]),
        .div_signed(div_signed[0]), .div_dividend(div_dividend[0]),
        .div_divisor(div_divisor[0]), .div_q(div_q[0]), .div_r(div_r[0])
    );

    hilo_div_ctrl #(.DIV_LATENCY(LAT1), .WIDTH(32)) dut4 (
        .clock(clock), .reset(reset[1]), .op_valid(op_valid[1]), .op_code(op_code[1]),
        .rs_data(rs_data[1]), .rt_data(rt_data[1]), .rdata(rdata[1]), .stall(stall[1]),
        .busy(busy[1]), .done(done[1]), .div_zero(div_zero[1]), .div_start(div_start[1]),
        .div_signed(div_signed[1]), .div_dividend(div_dividend[1]),
        .div_divisor(div_divisor[1]), .div_q(div_q[1]), .div_r(div_r[1])
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic int lat(input int u);
        return (u == 0) ? LAT0 : LAT1;
    endfunction

    // Returns {remainder, quotient}; signed divide truncates toward zero.
    function automatic logic [63:0] ref_div(input logic sgn, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] q;
        logic [31:0] r;
        if (b == 32'd0) begin
            q = '1;
            r = a;
        end else if (sgn) begin
            q = 32'($signed(a) / $signed(b));
            r = 32'($signed(a) % $signed(b));
        end else begin
            q = a / b;
            r = a % b;
        end
        return {r, q};
    endfunction

    // Divider model: result valid only DIV_LATENCY cycles after the start-pulse cycle.
    always @(posedge clock) begin
        for (int u = 0; u < 2; u++) begin
            if (div_start[u]) begin
                m_res[u]  <= ref_div(div_signed[u], div_dividend[u], div_divisor[u]);
                m_rem[u]  <= lat(u) - 1;
                m_have[u] <= 1'b1;
            end else if (m_rem[u] != 0) begin
                m_rem[u] <= m_rem[u] - 1;
            end
        end
    end

    always_comb begin
        for (int u = 0; u < 2; u++) begin
            div_q[u] = 32'hDEADBEEF;
            div_r[u] = 32'hBADC0DE0;
            if (m_have[u] && (m_rem[u] == 0)) begin
                div_q[u] = m_res[u][31:0];
                div_r[u] = m_res[u][63:32];
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic idle_op(input int u);
        op_valid[u] = 1'b0;
        op_code[u]  = 3'd0;
        rs_data[u]  = 32'd0;
        rt_data[u]  = 32'd0;
    endtask

    task automatic drive(input int u, input logic [2:0] code, input logic [31:0] a, input logic [31:0] b);
        op_valid[u] = 1'b1;
        op_code[u]  = code;
        rs_data[u]  = a;
        rt_data[u]  = b;
    endtask

    task automatic mt(input int u, input logic sel_hi, input logic [31:0] val);
        @(negedge clock);
        drive(u, sel_hi ? 3'd3 : 3'd4, val, 32'd0);
        #1 chk("mt_stall", stall[u], 0);
        @(posedge clock);
        #1 idle_op(u);
    endtask

    task automatic rd(input int u, input logic sel_hi, input logic [31:0] exp, input string tag);
        @(negedge clock);
        drive(u, sel_hi ? 3'd5 : 3'd6, 32'd0, 32'd0);
        #1 chk("rd_stall", stall[u], 0);
        chk(tag, rdata[u], exp);
        @(posedge clock);
        #1 idle_op(u);
    endtask

    task automatic do_div(input int u, input logic sgn, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] e;
        int busy_n;
        int done_n;
        int done_at;
        sb.push_back(ref_div(sgn, a, b));
        @(negedge clock);
        drive(u, sgn ? 3'd1 : 3'd2, a, b);
        #1 chk("div_acc_stall", stall[u], 0);
        chk("div_no_early_start", div_start[u], 0);
        @(posedge clock);
        #1 idle_op(u);
        busy_n = 0;
        done_n = 0;
        done_at = 0;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clock);
            #1;
            if (c == 1) begin
                chk("start_pulse", div_start[u], 1);
                chk("div_signed", div_signed[u], sgn);
                chk("div_dividend", div_dividend[u], a);
                chk("div_divisor", div_divisor[u], b);
            end else if (div_start[u]) begin
                chk("start_once", div_start[u], 0);
            end
            if (busy[u]) busy_n++;
            if (done[u]) begin
                done_n++;
                if (done_at == 0) done_at = c;
            end
            if (!busy[u]) break;
        end
        chk("div_end_bound", busy[u], 0);
        chk("busy_cycles", busy_n, 1 + lat(u));
        chk("done_cycle", done_at, 1 + lat(u));
        chk("done_pulses", done_n, 1);
        e = sb.pop_front();
        drive(u, 3'd6, 32'd0, 32'd0);
        #1 chk("div_lo", rdata[u], e[31:0]);
        op_code[u] = 3'd5;
        #1 chk("div_hi", rdata[u], e[63:32]);
        @(posedge clock);
        #1 idle_op(u);
    endtask

    task automatic reset_in_wait(input int u, input int wait_cycles);
        mt(u, 1'b1, 32'h55);
        mt(u, 1'b0, 32'h66);
        @(negedge clock);
        drive(u, 3'd1, 32'd50, 32'd3);
        @(posedge clock);
        #1 idle_op(u);
        repeat (1 + wait_cycles) @(negedge clock);
        reset[u] = 1'b1;
        #1 chk("rst_in_wait_busy", busy[u], 1);
        chk("rst_done_masked", done[u], 0);
        @(negedge clock);
        reset[u] = 1'b0;
        #1 chk("rst_idle", busy[u], 0);
        for (int c = 0; c < 6; c++) begin
            @(negedge clock);
            #1;
            if (done[u] || busy[u]) chk("rst_no_late_done", {done[u], busy[u]}, 0);
        end
        rd(u, 1'b1, 32'd0, "rst_hi_cleared");
        rd(u, 1'b0, 32'd0, "rst_lo_cleared");
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a;
        logic [31:0] b;
        logic        s;
        for (int u = 0; u < 2; u++) begin
            reset[u]  = 1'b1;
            m_have[u] = 1'b0;
            m_rem[u]  = 0;
            idle_op(u);
        end
        repeat (3) @(negedge clock);
        #1;
        chk("rst_busy", busy[0], 0);
        chk("rst_done", done[0], 0);
        chk("rst_start", div_start[0], 0);
        chk("rst_dz", div_zero[0], 0);
        chk("rst_signed", div_signed[0], 0);
        chk("rst_dividend", div_dividend[0], 0);
        chk("rst_divisor", div_divisor[0], 0);
        chk("rst_stall", stall[0], 0);
        reset[0] = 1'b0;
        reset[1] = 1'b0;
        rd(0, 1'b1, 32'd0, "rst_hi");
        rd(0, 1'b0, 32'd0, "rst_lo");

        do_div(0, 1'b1, 32'd7, 32'hFFFFFFFE);
        do_div(0, 1'b0, 32'hFFFFFFFF, 32'd2);

        // Divide by zero leaves HI/LO alone and never goes busy.
        mt(0, 1'b1, 32'd5);
        mt(0, 1'b0, 32'd9);
        @(negedge clock);
        drive(0, 3'd1, 32'd3, 32'd0);
        #1 chk("dz_acc_stall", stall[0], 0);
        @(posedge clock);
        #1 idle_op(0);
        @(negedge clock);
        #1 chk("dz_pulse", div_zero[0], 1);
        chk("dz_no_start", div_start[0], 0);
        chk("dz_no_busy", busy[0], 0);
        @(negedge clock);
        #1 chk("dz_pulse_end", div_zero[0], 0);
        chk("dz_no_start2", div_start[0], 0);
        chk("dz_no_busy2", busy[0], 0);
        rd(0, 1'b1, 32'd5, "dz_hi");
        rd(0, 1'b0, 32'd9, "dz_lo");

        // MFLO right behind a DIV stalls until the new LO is in place.
        sb.push_back(ref_div(1'b0, 32'd100, 32'd7));
        @(negedge clock);
        drive(0, 3'd2, 32'd100, 32'd7);
        @(posedge clock);
        #1 drive(0, 3'd6, 32'd0, 32'd0);
        @(negedge clock);
        #1 chk("mf_stall_t1", stall[0], 1);
        @(negedge clock);
        #1 chk("mf_stall_t2", stall[0], 1);
        chk("mf_done_t2", done[0], 1);
        @(negedge clock);
        #1 chk("mf_stall_t3", stall[0], 0);
        begin
            logic [63:0] e;
            e = sb.pop_front();
            chk("mf_new_lo", rdata[0], e[31:0]);
        end
        @(posedge clock);
        #1 idle_op(0);

        mt(0, 1'b1, 32'h1234);
        rd(0, 1'b1, 32'h1234, "mthi_mfhi");
        mt(0, 1'b0, 32'hABCD);
        rd(0, 1'b0, 32'hABCD, "mtlo_mflo");

        @(negedge clock);
        drive(0, 3'd7, 32'h1, 32'h2);
        #1 chk("op7_stall", stall[0], 0);
        chk("op7_rdata", rdata[0], 0);
        @(posedge clock);
        #1 idle_op(0);
        @(negedge clock);
        #1 chk("op7_busy", busy[0], 0);

        for (int i = 0; i < 4; i++) begin
            s = 1'($urandom_range(0, 1));
            a = $urandom;
            b = $urandom;
            if (b == 32'd0) b = 32'd13;
            if (s && (a == 32'h80000000) && (b == 32'hFFFFFFFF)) b = 32'd3;
            do_div(0, s, a, b);
        end

        reset_in_wait(0, 1);

        do_div(1, 1'b1, 32'hFFFFFF9C, 32'd7);
        do_div(1, 1'b0, 32'd1000, 32'd33);
        reset_in_wait(1, 2);

        chk("sb_empty", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
